mpe_sched: RTL and testbench
============================

MPE_SCHED -- requirements
Module: mpe_sched

Interface
REQ-001 Parameters SHALL be:
- WORD_SZ, default 64, data word width.
- PIPE_LAT, default 3, cycles from a gene-issue cycle until the matching child appears on mpe_child.
- LFSR_SEED, default 32'hACE1_0001, non-zero LFSR reset value.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset.
- job_valid  in  1  job descriptor offered.
- job_ready  out  1  controller accepts a job.
- job_cfg  in  WORD_SZ  packed fitness/mutation-probability setup word.
- job_child_id  in  8  child genome id.
- job_num_genes  in  8  gene pairs in the job, 0..255.
- gene_valid  in  1  parent gene pair offered.
- gene_ready  out  1  controller accepts the pair.
- gene1  in  WORD_SZ  parent-1 gene.
- gene2  in  WORD_SZ  parent-2 gene.
- mpe_setup  out  1  PE setup strobe.
- mpe_data1  out  WORD_SZ  PE data_in1.
- mpe_data2  out  WORD_SZ  PE data_in2.
- mpe_rand  out  WORD_SZ  PE random_num_pack.
- mpe_child  in  WORD_SZ  PE child_gene.
- child_valid  out  1  child gene valid (no backpressure).
- child_gene  out  WORD_SZ  child gene.
- child_last  out  1  final child of the job.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
REQ-003 The design SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, SETUP, STREAM, DRAIN and DONE.
REQ-005 IDLE: job_ready=1. On job_valid&job_ready, the controller SHALL latch cfg, child_id and num_genes, then go to SETUP.
REQ-006 SETUP SHALL last exactly 1 cycle, driving:
- mpe_setup=1, mpe_data1=job_cfg, mpe_data2={zeros, child_id}.
- Next state: STREAM if num_genes>0, else DRAIN.
REQ-007 STREAM: gene_ready=1 while issued<num_genes. Each gene_valid&gene_ready cycle is an issue cycle: mpe_data1=gene1, mpe_data2=gene2, and issued increments.
REQ-008 In non-issue cycles outside SETUP, mpe_setup=0 and mpe_data1/mpe_data2=0.
REQ-009 A PIPE_LAT-deep tag shift register SHALL record issue cycles; it shifts every cycle in every state.
REQ-010 child_valid SHALL be 1 exactly PIPE_LAT cycles after each issue cycle, with child_gene=mpe_child registered through. Children for non-issue (bubble) cycles SHALL never be flagged.
REQ-011 child_last SHALL be 1 with the child whose emitted count equals num_genes.
REQ-012 STREAM SHALL go to DRAIN in the cycle after the num_genes-th issue, and gene_ready=0 from then on.
REQ-013 DRAIN SHALL go to DONE when the tag register is empty and emitted==num_genes. DONE SHALL pulse done=1 for 1 cycle, then return to IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 A job with num_genes=0 SHALL produce no child_valid, and done SHALL pulse 3 cycles after acceptance (SETUP, DRAIN, DONE).
REQ-016 The 32-bit Galois LFSR (x^32+x^22+x^2+x+1) SHALL advance every cycle; mpe_rand={zeros, lfsr}.
REQ-017 The issued and emitted counters SHALL be 8 bits and SHALL not wrap: 255 is the maximum and ends STREAM.
REQ-018 job_valid in any state other than IDLE SHALL be ignored (job_ready=0).

Reset
REQ-019 rst=1 SHALL force, on the next edge:
- state=IDLE, counters=0, tag register cleared, lfsr=LFSR_SEED.
- Outputs: job_ready=1; gene_ready, mpe_setup, child_valid, child_last, busy and done all 0; mpe_data1, mpe_data2 and child_gene all 0.
REQ-020 A reset asserted mid-job SHALL abort the job. No child_valid or done SHALL follow it, even for genes already inside the PE.

Structure
REQ-021 Package mpe_pkg SHALL hold WORD_SZ, ATTR_SZ=8, the state enum, the LFSR polynomial and the default seed.
REQ-022 The LFSR SHALL be a sub-module mpe_lfsr (ports clk, rst, seed, out).

Verification
REQ-023 Job num_genes=3, genes offered back-to-back: SETUP cycle with mpe_setup=1, then 3 issue cycles; child_valid on cycles issue+3; child_last on the third child; done 1 cycle after the last child.
REQ-024 Job num_genes=4 with gene_valid toggling 1,0,1,0,1,0,1: exactly 4 child_valid pulses, each exactly 3 cycles after its issue cycle, and no pulses for bubbles.
REQ-025 Job num_genes=0: no child_valid; done exactly 3 cycles after the job handshake.
REQ-026 rst asserted in the cycle after the second issue of a 5-gene job: zero child_valid afterwards, and idle outputs per REQ-019 on the next edge.
REQ-027 num_genes=255 with continuous genes: 255 children, child_last only on the 255th, gene_ready=0 after issue 255.
REQ-028 job_valid held high across two jobs: the second job is accepted only in IDLE after done; mpe_rand equals the reference-model LFSR sequence from seed.

Source files
------------

// File: rtl/mpe_pkg.sv
// mpe_pkg: shared widths, scheduler states and LFSR constants for the MPE scheduler
package mpe_pkg;
  localparam int WORD_SZ = 64;
  localparam int ATTR_SZ = 8;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEF = 32'hACE1_0001;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STREAM, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/mpe_lfsr.sv
// mpe_lfsr: 32-bit Galois LFSR for x^32+x^22+x^2+x+1, advancing every cycle
module mpe_lfsr
  import mpe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] seed,
  output logic [31:0] out
);
  // shift right and fold the dropped bit back through the tap mask
  always_ff @(posedge clk)
    if (rst) out <= seed;
    else out <= (out >> 1) ^ (out[0] ? LFSR_POLY : 32'h0);
endmodule

// File: rtl/mpe_sched.sv
// mpe_sched: feeds parent gene pairs into a fixed-latency PE and collects the children
module mpe_sched #(
  parameter int          WORD_SZ   = mpe_pkg::WORD_SZ,
  parameter int          PIPE_LAT  = 3,
  parameter logic [31:0] LFSR_SEED = mpe_pkg::LFSR_SEED_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [WORD_SZ-1:0]         job_cfg,
  input  logic [mpe_pkg::ATTR_SZ-1:0] job_child_id,
  input  logic [mpe_pkg::ATTR_SZ-1:0] job_num_genes,
  input  logic                       gene_valid,
  output logic                       gene_ready,
  input  logic [WORD_SZ-1:0]         gene1,
  input  logic [WORD_SZ-1:0]         gene2,
  output logic                       mpe_setup,
  output logic [WORD_SZ-1:0]         mpe_data1,
  output logic [WORD_SZ-1:0]         mpe_data2,
  output logic [WORD_SZ-1:0]         mpe_rand,
  input  logic [WORD_SZ-1:0]         mpe_child,
  output logic                       child_valid,
  output logic [WORD_SZ-1:0]         child_gene,
  output logic                       child_last,
  output logic                       busy,
  output logic                       done
);
  import mpe_pkg::*;
  localparam logic [PIPE_LAT-1:0] TAG_TOP = PIPE_LAT'(1) << (PIPE_LAT - 1);
  state_t state, state_n;
  logic [WORD_SZ-1:0] cfg_q;
  logic [ATTR_SZ-1:0] id_q, n_q, issued, emitted;
  logic [ATTR_SZ:0] emit_n;
  logic [PIPE_LAT-1:0] tag;
  logic [31:0] lfsr;
  logic issue;
  mpe_lfsr u_lfsr (.clk(clk), .rst(rst), .seed(LFSR_SEED), .out(lfsr));
  // state register
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : state_n;
  // next state; DRAIN ends once the child on the output now is the last one outstanding
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   state_n = job_valid ? S_SETUP : S_IDLE;
      S_SETUP:  state_n = n_q != '0 ? S_STREAM : S_DRAIN;
      S_STREAM: state_n = issued == n_q ? S_DRAIN : S_STREAM;
      S_DRAIN:  state_n = ((tag & ~TAG_TOP) == '0 && emit_n == {1'b0, n_q}) ? S_DONE : S_DRAIN;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end
  // handshakes, PE drive and child flags
  always_comb begin
    job_ready = state == S_IDLE;
    busy = state != S_IDLE;
    done = state == S_DONE;
    mpe_setup = state == S_SETUP;
    gene_ready = state == S_STREAM && issued < n_q;
    issue = gene_valid && gene_ready;
    mpe_data1 = mpe_setup ? cfg_q : issue ? gene1 : '0;
    mpe_data2 = mpe_setup ? WORD_SZ'(id_q) : issue ? gene2 : '0;
    mpe_rand = WORD_SZ'(lfsr);
    child_valid = tag[PIPE_LAT-1];
    emit_n = {1'b0, emitted} + {{ATTR_SZ{1'b0}}, child_valid};
    child_last = child_valid && emit_n == {1'b0, n_q};
  end
  // job latch, saturating counters, issue tag pipe and child capture
  always_ff @(posedge clk)
    if (rst) begin
      cfg_q <= '0;
      id_q <= '0;
      n_q <= '0;
      issued <= '0;
      emitted <= '0;
      tag <= '0;
      child_gene <= '0;
    end else begin
      if (job_valid && job_ready) begin
        cfg_q <= job_cfg;
        id_q <= job_child_id;
        n_q <= job_num_genes;
        issued <= '0;
        emitted <= '0;
      end else begin
        if (issue && issued != '1) issued <= issued + ATTR_SZ'(1);
        if (child_valid && emitted != '1) emitted <= emitted + ATTR_SZ'(1);
      end
      tag <= (tag << 1) | PIPE_LAT'(issue);
      child_gene <= mpe_child;
    end
endmodule

// File: tb/tb_mpe_sched.sv
// tb_mpe_sched: randomized scoreboard bench for the MPE gene scheduler
module tb_mpe_sched;
  localparam int W = 64;
  localparam int PL = 3;
  localparam logic [31:0] SEED = 32'hACE1_0001;
  typedef struct { int cyc; logic [W-1:0] gene; bit last; } exp_t;
  logic clk = 0, rst = 1;
  logic job_valid = 0, gene_valid = 0;
  logic [W-1:0] job_cfg = '0, gene1 = '0, gene2 = '0;
  logic [7:0] job_child_id = '0, job_num_genes = '0;
  logic job_ready, gene_ready, mpe_setup, child_valid, child_last, busy, done;
  logic [W-1:0] mpe_data1, mpe_data2, mpe_rand, mpe_child, child_gene;
  logic [W-1:0] pe1, pe2;
  logic [31:0] lfsr_m;
  bit seeded = 0;
  int cyc = 0, checks = 0, errors = 0;
  exp_t sb[$];
  int done_q[$];
  exp_t e_m;

  mpe_sched #(.WORD_SZ(W), .PIPE_LAT(PL), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready), .job_cfg(job_cfg),
    .job_child_id(job_child_id), .job_num_genes(job_num_genes), .gene_valid(gene_valid),
    .gene_ready(gene_ready), .gene1(gene1), .gene2(gene2), .mpe_setup(mpe_setup),
    .mpe_data1(mpe_data1), .mpe_data2(mpe_data2), .mpe_rand(mpe_rand), .mpe_child(mpe_child),
    .child_valid(child_valid), .child_gene(child_gene), .child_last(child_last),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  // next LFSR value from the polynomial terms x^32, x^22, x^2, x^1
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) begin r[31] = ~r[31]; r[21] = ~r[21]; r[1] = ~r[1]; r[0] = ~r[0]; end
    return r;
  endfunction

  // cycle count, PE model (child = data1 ^ data2, visible on mpe_child PL-1 cycles later), LFSR model
  always @(posedge clk) begin
    cyc <= cyc + 1;
    pe1 <= mpe_data1 ^ mpe_data2;
    pe2 <= pe1;
    lfsr_m <= rst ? SEED : lfsr_step(lfsr_m);
    if (rst) seeded <= 1;
  end
  assign mpe_child = pe2;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // monitor: compares every presented child and done pulse against the scoreboard
  always @(negedge clk) if (seeded && !rst) begin
    chk("mpe_rand", mpe_rand, {32'b0, lfsr_m});
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL child_missing cyc=%0d want_cyc=%0d", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    while (done_q.size() > 0 && done_q[0] < cyc) begin
      checks++; errors++;
      $display("FAIL done_missing cyc=%0d want_cyc=%0d", cyc, done_q[0]);
      void'(done_q.pop_front());
    end
    if (child_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL child_unexpected cyc=%0d gene=%h", cyc, child_gene);
      end else begin
        e_m = sb.pop_front();
        chk("child_cyc", W'(cyc), W'(e_m.cyc));
        chk("child_gene", child_gene, e_m.gene);
        chk("child_last", W'(child_last), W'(e_m.last));
      end
    end else chk("child_last_idle", W'(child_last), 0);
    if (done) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected cyc=%0d", cyc);
      end else chk("done_cyc", W'(cyc), W'(done_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string nm);
    chk({nm, "_job_ready"}, W'(job_ready), 1);
    chk({nm, "_gene_ready"}, W'(gene_ready), 0);
    chk({nm, "_setup"}, W'(mpe_setup), 0);
    chk({nm, "_child_valid"}, W'(child_valid), 0);
    chk({nm, "_child_last"}, W'(child_last), 0);
    chk({nm, "_busy"}, W'(busy), 0);
    chk({nm, "_done"}, W'(done), 0);
    chk({nm, "_data"}, mpe_data1 | mpe_data2, 0);
    chk({nm, "_child_gene"}, child_gene, 0);
  endtask

  // mode 0 back-to-back genes, 1 alternating 1,0,1,..., 2 random bubbles
  task automatic run_job(input int n, input int mode, input bit hold, input int want_acc,
                         input int abort_at, output int done_at);
    logic [W-1:0] cfg;
    logic [7:0] id;
    int issued, acc, t, last, k;
    cfg = {$urandom, $urandom};
    id = 8'($urandom);
    issued = 0; t = 0; last = 0; k = 0;
    job_valid = 1; job_cfg = cfg; job_child_id = id; job_num_genes = 8'(n);
    #1;
    while (!job_ready && t < 600) begin tick(); #1; t++; end
    if (!job_ready) begin checks++; errors++; $display("FAIL job_accept_timeout cyc=%0d", cyc); end
    acc = cyc;
    if (want_acc >= 0) chk("accept_cyc", W'(acc), W'(want_acc));
    tick();
    if (!hold) job_valid = 0;
    #1;
    chk("setup_strobe", W'(mpe_setup), 1);
    chk("setup_data1", mpe_data1, cfg);
    chk("setup_data2", mpe_data2, W'(id));
    chk("setup_job_ready", W'(job_ready), 0);
    chk("setup_gene_ready", W'(gene_ready), 0);
    while (issued < n) begin
      tick();
      if (abort_at > 0 && issued == abort_at) break;
      gene_valid = (mode == 0) || (mode == 1 && k % 2 == 0) || (mode == 2 && $urandom_range(0, 2) != 0);
      gene1 = {$urandom, $urandom};
      gene2 = {$urandom, $urandom};
      #1;
      chk("stream_gene_ready", W'(gene_ready), 1);
      if (gene_valid) begin
        chk("issue_data1", mpe_data1, gene1);
        chk("issue_data2", mpe_data2, gene2);
        issued++;
        sb.push_back('{cyc + PL, gene1 ^ gene2, bit'(issued == n)});
        last = cyc;
      end else chk("bubble_data", mpe_data1 | mpe_data2, 0);
      k++;
    end
    if (abort_at > 0) begin
      rst = 1; gene_valid = 0; sb.delete();
      tick();
      rst = 0;
      #1;
      idle_chk("abort");
      repeat (8) tick();
      done_at = cyc;
      return;
    end
    tick();
    gene_valid = 1'($urandom_range(0, 1));
    #1;
    chk("post_gene_ready", W'(gene_ready), 0);
    chk("post_data", mpe_data1 | mpe_data2, 0);
    chk("post_busy", W'(busy), 1);
    done_at = n == 0 ? acc + 3 : last + PL + 1;
    done_q.push_back(done_at);
    gene_valid = 0;
    while (cyc < done_at + 1) tick();
    #1;
    chk("idle_job_ready", W'(job_ready), 1);
    chk("idle_busy", W'(busy), 0);
  endtask

  initial begin
    int d;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    #1;
    idle_chk("reset");
    run_job(3, 0, 0, -1, 0, d);
    run_job(4, 1, 0, -1, 0, d);
    run_job(0, 0, 0, -1, 0, d);
    run_job(5, 0, 0, -1, 2, d);
    run_job(255, 0, 0, -1, 0, d);
    run_job(6, 0, 1, -1, 0, d);
    run_job(2, 2, 0, d + 1, 0, d);
    repeat (6) run_job($urandom_range(1, 20), $urandom_range(0, 2), 0, -1, 0, d);
    repeat (6) tick();
    chk("sb_leftover", W'(sb.size()), 0);
    chk("done_leftover", W'(done_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
